axi3_rd_arbiter: RTL and testbench

- Shares one AXI3 read port (AR + R channels) between N_MASTER read requesters, e.g. dcache line refill, uncached/pass-through reads and icache refill, before the port reaches mem_device or the top-level bus.
- Allows one outstanding burst at a time, with round-robin arbitration.
- The grant is held from AR acceptance until the last R beat completes.

---
 rtl/axi3_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_axi3_rd_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read port, one burst in flight.
// Define AXI_RD_ARB_FIXED_PRIO_EN to give master 0 absolute priority.
module axi3_rd_arbiter #(
   parameter int N_MASTER   = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 4,
   localparam int GW        = $clog2(N_MASTER)
) (
   input  logic                           clk,
   input  logic                           sync_rst,
   input  logic [N_MASTER-1:0]            m_arvalid,
   input  logic [N_MASTER*ADDR_WIDTH-1:0] m_araddr,
   input  logic [N_MASTER*LEN_WIDTH-1:0]  m_arlen,
   input  logic [N_MASTER*ID_WIDTH-1:0]   m_arid,
   output logic [N_MASTER-1:0]            m_arready,
   output logic [N_MASTER-1:0]            m_rvalid,
   output logic [DATA_WIDTH-1:0]          m_rdata,
   output logic                           m_rlast,
   output logic [ID_WIDTH-1:0]            m_rid,
   input  logic [N_MASTER-1:0]            m_rready,
   output logic                           s_arvalid,
   output logic [ADDR_WIDTH-1:0]          s_araddr,
   output logic [LEN_WIDTH-1:0]           s_arlen,
   output logic [ID_WIDTH-1:0]            s_arid,
   input  logic                           s_arready,
   input  logic                           s_rvalid,
   input  logic [DATA_WIDTH-1:0]          s_rdata,
   input  logic                           s_rlast,
   input  logic [ID_WIDTH-1:0]            s_rid,
   output logic                           s_rready,
   output logic [GW-1:0]                  grant,
   output logic                           busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [GW-1:0] gnt_q;
   logic [GW-1:0] gnt_nxt;
   logic [GW-1:0] ptr_q;
   logic [GW-1:0] ptr_nxt;
   logic [GW-1:0] pick;
   logic          ar_hs;
   logic          r_done;

   logic [ADDR_WIDTH-1:0] addr_a [N_MASTER];
   logic [LEN_WIDTH-1:0]  len_a  [N_MASTER];
   logic [ID_WIDTH-1:0]   id_a   [N_MASTER];

   for (genvar i = 0; i < N_MASTER; i++) begin : g_sl
      assign addr_a[i] = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_a[i]  = m_arlen[i*LEN_WIDTH +: LEN_WIDTH];
      assign id_a[i]   = m_arid[i*ID_WIDTH +: ID_WIDTH];
   end

   // Scan from the far end so the requester nearest ptr is assigned last.
   always_comb begin
      logic [GW-1:0] idx;
      pick = ptr_q;
      for (int k = N_MASTER - 1; k >= 0; k--) begin
         idx = GW'((int'(ptr_q) + k) % N_MASTER);
         if (m_arvalid[idx]) pick = idx;
      end
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      if (m_arvalid[0]) pick = '0;
`endif
   end

   assign ar_hs  = (state == ADDR) & m_arvalid[gnt_q] & s_arready;
   assign r_done = (state == DATA) & s_rvalid & m_rready[gnt_q] & s_rlast;

   always_ff @(posedge clk or posedge sync_rst) begin
      if (sync_rst) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or posedge sync_rst) begin
      if (sync_rst) begin
         gnt_q <= '0;
         ptr_q <= '0;
      end else begin
         gnt_q <= gnt_nxt;
         ptr_q <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      ptr_nxt   = ptr_q;
      unique case (state)
         IDLE: begin
            if (|m_arvalid) begin
               gnt_nxt   = pick;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (ar_hs) state_nxt = DATA;
         end
         DATA: begin
            if (r_done) begin
               state_nxt = IDLE;
               ptr_nxt   = (gnt_q == GW'(N_MASTER - 1)) ? '0 : gnt_q + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_arready = '0;
      m_rvalid  = '0;
      m_rdata   = '0;
      m_rlast   = 1'b0;
      m_rid     = '0;
      s_arvalid = 1'b0;
      s_araddr  = '0;
      s_arlen   = '0;
      s_arid    = '0;
      s_rready  = 1'b0;
      busy      = (state != IDLE);
      grant     = busy ? gnt_q : '0;
      unique case (state)
         ADDR: begin
            s_arvalid        = m_arvalid[gnt_q];
            s_araddr         = addr_a[gnt_q];
            s_arlen          = len_a[gnt_q];
            s_arid           = id_a[gnt_q];
            m_arready[gnt_q] = s_arready;
         end
         DATA: begin
            m_rvalid[gnt_q] = s_rvalid;
            s_rready        = m_rready[gnt_q];
            m_rdata         = s_rdata;
            m_rlast         = s_rlast;
            m_rid           = s_rid;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Scoreboard bench for axi3_rd_arbiter: directed bursts, stalls, resets.
// Expectations switch with AXI_RD_ARB_FIXED_PRIO_EN.
module tb_axi3_rd_arbiter;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic sync_rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    m_arvalid;
   logic [N*AW-1:0] m_araddr;
   logic [N*LW-1:0] m_arlen;
   logic [N*IW-1:0] m_arid;
   logic [N-1:0]    m_arready;
   logic [N-1:0]    m_rvalid;
   logic [DW-1:0]   m_rdata;
   logic            m_rlast;
   logic [IW-1:0]   m_rid;
   logic [N-1:0]    m_rready = '1;
   logic            s_arvalid;
   logic [AW-1:0]   s_araddr;
   logic [LW-1:0]   s_arlen;
   logic [IW-1:0]   s_arid;
   logic            s_arready = 1'b1;
   logic            s_rvalid = 1'b0;
   logic [DW-1:0]   s_rdata = '0;
   logic            s_rlast = 1'b0;
   logic [IW-1:0]   s_rid = '0;
   logic            s_rready;
   logic [1:0]      grant;
   logic            busy;

   axi3_rd_arbiter #(
      .N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .ID_WIDTH(IW), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .sync_rst(sync_rst),
      .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_arid(m_arid), .m_arready(m_arready), .m_rvalid(m_rvalid),
      .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rid(m_rid),
      .m_rready(m_rready), .s_arvalid(s_arvalid), .s_araddr(s_araddr),
      .s_arlen(s_arlen), .s_arid(s_arid), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast),
      .s_rid(s_rid), .s_rready(s_rready), .grant(grant), .busy(busy)
   );

   typedef struct {
      int            m;
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      logic [IW-1:0] id;
   } ar_t;
   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic [IW-1:0] id;
   } r_t;

   ar_t exp_ar[$];
   r_t  exp_r[$];
   int  total = 0;
   int  bad = 0;
   int  r_beats = 0;

   // master request model: request k of master i is pending while ack<req
   logic [AW-1:0] base_r [N];
   logic [LW-1:0] len_r  [N];
   logic [IW-1:0] id_r   [N];
   int req_total [N] = '{default: 0};
   int ack_cnt   [N] = '{default: 0};

   always_comb begin
      for (int i = 0; i < N; i++) begin
         m_arvalid[i]          = (ack_cnt[i] != req_total[i]);
         m_araddr[i*AW +: AW]  = base_r[i];
         m_arlen[i*LW +: LW]   = len_r[i];
         m_arid[i*IW +: IW]    = id_r[i];
      end
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   // slave model: data of beat b = araddr + b, rid echoes arid
   logic [N-1:0]  smp_mar;
   logic          smp_ar;
   logic          smp_r;
   logic [AW-1:0] smp_addr;
   logic [LW-1:0] smp_len;
   logic [IW-1:0] smp_id;
   logic          active = 1'b0;
   int            beat = 0;
   logic [AW-1:0] cur_addr = '0;
   logic [LW-1:0] cur_len = '0;
   logic [IW-1:0] cur_id = '0;

   always @(negedge clk) begin
      smp_mar  = m_arvalid & m_arready;
      smp_ar   = s_arvalid & s_arready;
      smp_addr = s_araddr;
      smp_len  = s_arlen;
      smp_id   = s_arid;
      smp_r    = s_rvalid & s_rready;
   end

   always @(posedge clk) begin
      #1;
      if (sync_rst) begin
         active = 1'b0;
      end else begin
         for (int i = 0; i < N; i++)
            if (smp_mar[i]) ack_cnt[i]++;
         if (smp_r) begin
            if (beat == int'(cur_len)) active = 1'b0;
            else beat++;
         end
         if (smp_ar) begin
            active   = 1'b1;
            beat     = 0;
            cur_addr = smp_addr;
            cur_len  = smp_len;
            cur_id   = smp_id;
         end
      end
      s_rvalid = active;
      s_rdata  = cur_addr + DW'(beat);
      s_rlast  = active && (beat == int'(cur_len));
      s_rid    = cur_id;
   end

   // monitor / scoreboard
   int   exp_g = 0;
   bit   dphase = 1'b0;
   bit   idle_chk = 1'b0;

   always @(negedge clk) begin
      ar_t a;
      r_t  r;
      logic [N-1:0] oh;
      if (sync_rst) begin
         dphase   = 1'b0;
         idle_chk = 1'b0;
      end else begin
         if (idle_chk) begin
            chk("idle_gap", {62'd0, busy, s_arvalid}, 64'd0);
            idle_chk = 1'b0;
         end
         oh = N'(1) << exp_g;
         if (dphase)
            chk("r_route", {57'd0, m_rvalid, s_rready, s_arvalid, 2'd0},
                {57'd0, s_rvalid ? oh : 3'b000, m_rready[exp_g], 1'b0, 2'd0});
         else
            chk("r_idle", {60'd0, m_rvalid, s_rready}, 64'd0);
         if (s_rvalid && s_rready) begin
            if (exp_r.size() == 0) begin
               chk("r_unexpected", 64'd1, 64'd0);
            end else begin
               r = exp_r.pop_front();
               chk("r_data", 64'(m_rdata), 64'(r.data));
               chk("r_last", 64'(m_rlast), 64'(r.last));
               chk("r_id", 64'(m_rid), 64'(r.id));
            end
            r_beats++;
            if (s_rlast) begin
               dphase   = 1'b0;
               idle_chk = 1'b1;
            end
         end
         if (s_arvalid && s_arready) begin
            if (exp_ar.size() == 0) begin
               chk("ar_unexpected", 64'd1, 64'd0);
            end else begin
               a = exp_ar.pop_front();
               chk("ar_grant", 64'(grant), 64'(a.m));
               chk("ar_addr", 64'(s_araddr), 64'(a.addr));
               chk("ar_len", 64'(s_arlen), 64'(a.len));
               chk("ar_id", 64'(s_arid), 64'(a.id));
               chk("ar_ready", 64'(m_arready), 64'(N'(1) << a.m));
               exp_g  = a.m;
               dphase = 1'b1;
            end
         end
      end
   end

   task automatic setm(int i, logic [AW-1:0] ad, logic [LW-1:0] ln,
                       logic [IW-1:0] id);
      base_r[i] = ad;
      len_r[i]  = ln;
      id_r[i]   = id;
   endtask

   task automatic expect_burst(int m, logic [AW-1:0] ad, logic [LW-1:0] ln,
                               logic [IW-1:0] id, int nb);
      ar_t a;
      r_t  r;
      a.m = m; a.addr = ad; a.len = ln; a.id = id;
      exp_ar.push_back(a);
      for (int b = 0; b < nb; b++) begin
         r.data = ad + DW'(b);
         r.last = (b == int'(ln));
         r.id   = id;
         exp_r.push_back(r);
      end
   endtask

   task automatic issue(logic [N-1:0] mk, int cnt);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (mk[i]) req_total[i] += cnt;
   endtask

   task automatic wait_beats(int n);
      for (int c = 0; c < 300 && r_beats < n; c++) begin
         @(negedge clk);
         #1;
      end
      chk("beat_wait", 64'(r_beats >= n), 64'd1);
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int c = 0; c < 600 && !done; c++) begin
         @(negedge clk);
         #1;
         done = (exp_ar.size() == 0) && (exp_r.size() == 0) && !busy;
      end
      chk("drain", 64'(done), 64'd1);
      @(negedge clk);
   endtask

   task automatic chk_zero(string nm);
      chk(nm, {8'd0, s_arvalid, s_rready, busy, grant, m_arready, m_rvalid,
               m_rlast, m_rid, s_arlen, s_arid, s_araddr[15:0], m_rdata[15:0]},
          64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      sync_rst = 1'b1;
      #1;
      chk_zero("rst_outs");
      repeat (2) @(posedge clk);
      #1;
      sync_rst = 1'b0;
   endtask

   initial begin
      int n0;
      for (int i = 0; i < N; i++) setm(i, '0, '0, '0);
      repeat (2) @(negedge clk);
      chk_zero("reset_state");
      @(posedge clk);
      #1;
      sync_rst = 1'b0;

      // single master 1, 8 beats, arbitration latency
      setm(1, 32'h0000_1000, 4'd7, 4'h3);
      expect_burst(1, 32'h0000_1000, 4'd7, 4'h3, 8);
      issue(3'b010, 1);
      @(negedge clk);
      chk("lat_idle", {62'd0, s_arvalid, busy}, 64'd0);
      @(negedge clk);
      chk("lat_addr", {60'd0, s_arvalid, busy, grant}, {60'd0, 1'b1, 1'b1, 2'd1});
      chk("lat_araddr", 64'(s_araddr), 64'h1000);
      wait_drain();

      // ptr now 2: masters 0 and 2 together
      setm(0, 32'h0000_1100, 4'd1, 4'h8);
      setm(2, 32'h0000_1200, 4'd1, 4'h9);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      expect_burst(0, 32'h0000_1100, 4'd1, 4'h8, 2);
      expect_burst(2, 32'h0000_1200, 4'd1, 4'h9, 2);
`else
      expect_burst(2, 32'h0000_1200, 4'd1, 4'h9, 2);
      expect_burst(0, 32'h0000_1100, 4'd1, 4'h8, 2);
`endif
      issue(3'b101, 1);
      wait_drain();

      // all three at once after reset: 0,1,2 then wrap to 0
      do_reset();
      setm(0, 32'h0000_2000, 4'd3, 4'h1);
      setm(1, 32'h0000_2100, 4'd3, 4'h2);
      setm(2, 32'h0000_2200, 4'd3, 4'h3);
      expect_burst(0, 32'h0000_2000, 4'd3, 4'h1, 4);
      expect_burst(1, 32'h0000_2100, 4'd3, 4'h2, 4);
      expect_burst(2, 32'h0000_2200, 4'd3, 4'h3, 4);
      issue(3'b111, 1);
      wait_drain();
      setm(0, 32'h0000_2800, 4'd0, 4'h4);
      setm(1, 32'h0000_2900, 4'd0, 4'h5);
      expect_burst(0, 32'h0000_2800, 4'd0, 4'h4, 1);
      expect_burst(1, 32'h0000_2900, 4'd0, 4'h5, 1);
      issue(3'b011, 1);
      wait_drain();

      // slave holds arready low 5 cycles
      s_arready = 1'b0;
      setm(2, 32'h0000_3000, 4'd3, 4'hC);
      expect_burst(2, 32'h0000_3000, 4'd3, 4'hC, 4);
      issue(3'b100, 1);
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("arstall_valid", {62'd0, s_arvalid, busy}, {62'd0, 2'b11});
         chk("arstall_ready", 64'(m_arready), 64'd0);
         chk("arstall_addr", {s_araddr, 24'd0, s_arlen, s_arid},
             {32'h0000_3000, 24'd0, 4'd3, 4'hC});
      end
      @(posedge clk);
      #1;
      s_arready = 1'b1;
      wait_drain();

      // master 1 stalls rready 3 cycles after 3 beats
      setm(1, 32'h0000_4000, 4'd7, 4'h5);
      expect_burst(1, 32'h0000_4000, 4'd7, 4'h5, 8);
      n0 = r_beats;
      issue(3'b010, 1);
      wait_beats(n0 + 3);
      @(posedge clk);
      #1;
      m_rready = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rstall_srready", 64'(s_rready), 64'd0);
         chk("rstall_rvalid", 64'(m_rvalid), 64'b010);
      end
      @(posedge clk);
      #1;
      m_rready = '1;
      wait_drain();

      // reset on beat 4 of 8, then ptr must restart at 0
      setm(1, 32'h0000_5000, 4'd7, 4'h6);
      expect_burst(1, 32'h0000_5000, 4'd7, 4'h6, 4);
      n0 = r_beats;
      issue(3'b010, 1);
      wait_beats(n0 + 4);
      sync_rst = 1'b1;
      #1;
      chk_zero("midrst_outs");
      repeat (2) @(posedge clk);
      #1;
      sync_rst = 1'b0;
      chk("midrst_queues", 64'(exp_ar.size() + exp_r.size()), 64'd0);
      setm(1, 32'h0000_6000, 4'd1, 4'h7);
      setm(2, 32'h0000_6200, 4'd1, 4'hD);
      expect_burst(1, 32'h0000_6000, 4'd1, 4'h7, 2);
      expect_burst(2, 32'h0000_6200, 4'd1, 4'hD, 2);
      issue(3'b110, 1);
      wait_drain();

      // masters 0 and 2 keep requesting
      do_reset();
      setm(0, 32'h0000_7000, 4'd1, 4'hA);
      setm(2, 32'h0000_7200, 4'd1, 4'hB);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      expect_burst(0, 32'h0000_7000, 4'd1, 4'hA, 2);
      expect_burst(0, 32'h0000_7000, 4'd1, 4'hA, 2);
      expect_burst(2, 32'h0000_7200, 4'd1, 4'hB, 2);
      expect_burst(2, 32'h0000_7200, 4'd1, 4'hB, 2);
`else
      expect_burst(0, 32'h0000_7000, 4'd1, 4'hA, 2);
      expect_burst(2, 32'h0000_7200, 4'd1, 4'hB, 2);
      expect_burst(0, 32'h0000_7000, 4'd1, 4'hA, 2);
      expect_burst(2, 32'h0000_7200, 4'd1, 4'hB, 2);
`endif
      issue(3'b101, 2);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
